// File: rtl/hexprint_scan_ctrl.sv
// hexprint_scan_ctrl: scans a 4*NUM_DIGITS-bit hex value onto one shared
// active-low 7-segment bus, one digit at a time, with an all-off guard
// interval before every digit. New values come in over valid/ready. They are
// held in a one-entry pending slot and copied to the displayed shadow only at
// a frame boundary, so a frame never mixes old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN keeps digits above the most
// significant nonzero nibble of the shadow dark. Digit 0 is always shown.
module hexprint_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Scan sequencer state
    logic [0:0]              r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;

    // Displayed (shadow) and waiting (pending) values
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_value_ready;   // low while the pending slot is occupied

    // Registered pin drivers
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic                    r_frame_done;

    logic                    w_blank_end;
    logic                    w_show_end;
    logic                    w_boundary;
    logic                    w_next_show;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_keep;
    logic [NUM_DIGITS-1:0]   w_show_mask;
    logic                    w_on;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_dp;
    logic [6:0]              w_font;

    assign w_blank_end = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
    assign w_show_end  = (r_state == ST_SHOW)  && (r_cnt == SHOW_LAST);
    assign w_boundary  = w_show_end && (r_idx == IDX_LAST);
    // Outputs are registered, so they follow the state the FSM is entering.
    assign w_next_show = (r_state == ST_BLANK) ? w_blank_end : !w_show_end;
    assign w_accept    = value_valid && r_value_ready;

    // Per-digit select decode and leading-zero keep mask
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_sel[gi] = (r_idx == IDX_W'(gi));
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign w_keep[gi] = 1'b1;
            end else begin : g_upper
                // Keep this digit if it or any more significant nibble is nonzero.
                assign w_keep[gi] = |r_shadow_val[4*NUM_DIGITS-1:4*gi];
            end
`else
            assign w_keep[gi] = 1'b1;
`endif
        end
    endgenerate

    assign w_show_mask = digit_en & w_keep;
    assign w_on        = |(w_sel & w_show_mask);

    // Select the nibble and decimal point of the digit under scan
    always_comb begin
        w_cur_nib = 4'h0;
        w_cur_dp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_cur_nib = r_shadow_val[4*i +: 4];
                w_cur_dp  = r_shadow_dp[i];
            end
        end
    end

    // Hex font, segments {g,f,e,d,c,b,a}, active-low
    always_comb begin
        case (w_cur_nib)
            4'h0:    w_font = 7'h40;
            4'h1:    w_font = 7'h79;
            4'h2:    w_font = 7'h24;
            4'h3:    w_font = 7'h30;
            4'h4:    w_font = 7'h19;
            4'h5:    w_font = 7'h12;
            4'h6:    w_font = 7'h02;
            4'h7:    w_font = 7'h78;
            4'h8:    w_font = 7'h00;
            4'h9:    w_font = 7'h10;
            4'hA:    w_font = 7'h08;
            4'hB:    w_font = 7'h03;
            4'hC:    w_font = 7'h46;
            4'hD:    w_font = 7'h21;
            4'hE:    w_font = 7'h06;
            default: w_font = 7'h0E;
        endcase
    end

    // BLANK/SHOW slot sequencer: cycle counter, state and digit index
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (w_blank_end) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
        end else if (w_show_end) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Value handshake: capture into pending, promote to shadow at frame boundary
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_shadow_val  <= '0;
            r_shadow_dp   <= '0;
            r_pend_val    <= '0;
            r_pend_dp     <= '0;
            r_value_ready <= 1'b1;
        end else if (w_boundary && !r_value_ready) begin
            r_shadow_val  <= r_pend_val;
            r_shadow_dp   <= r_pend_dp;
            r_value_ready <= 1'b1;
        end else if (w_accept) begin
            // An accept on the boundary cycle itself lands here and waits a frame.
            r_pend_val    <= value_in;
            r_pend_dp     <= dp_in;
            r_value_ready <= 1'b0;
        end
    end

    // Pin drivers: at most one anode low, everything off during BLANK
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_an_n       <= '1;
            r_seg_n      <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an_n       <= w_next_show ? ~(w_sel & w_show_mask) : '1;
            r_seg_n      <= (w_next_show && w_on) ? w_font : 7'h7F;
            r_dp_n       <= (w_next_show && w_on) ? ~w_cur_dp : 1'b1;
            r_frame_done <= w_boundary;
        end
    end

    assign value_ready = r_value_ready;
    assign an_n        = r_an_n;
    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign frame_done  = r_frame_done;

endmodule
